// File: rtl/riscv_base_alu_issue_pkg.sv
// Types local to the ALU issue stage: request bundle and buffer state.
// Optional skid buffer selected by RISCV_BASE_ALU_ISSUE_SKID_EN.
package riscv_base_alu_issue_pkg;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } alu_req_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/riscv_base_defines.sv
// Shared RV32I opcode constants and ALU opcode encodings.
// Used by every execute-side block of the core.
package riscv_base_defines;

    localparam logic [3:0] ALU_SHIFTL           = 4'b0001;
    localparam logic [3:0] ALU_SHIFTR           = 4'b0010;
    localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'b0011;
    localparam logic [3:0] ALU_ADD              = 4'b0100;
    localparam logic [3:0] ALU_SUB              = 4'b0110;
    localparam logic [3:0] ALU_AND              = 4'b0111;
    localparam logic [3:0] ALU_OR               = 4'b1000;
    localparam logic [3:0] ALU_XOR              = 4'b1001;
    localparam logic [3:0] ALU_LESS_THAN        = 4'b1010;
    localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'b1011;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

endpackage

// File: rtl/riscv_base_alu_decode.sv
// Combinational RV32I ALU-class decode: instruction/pc/operands to
// ALU opcode, operands, destination and illegal flag.
module riscv_base_alu_decode
    import riscv_base_defines::*;
(
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [3:0]  op_o,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [4:0]  rd_o,
    output logic        rd_we_o,
    output logic        illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        is_op;
    logic        is_imm;
    logic        is_lui;
    logic        is_auipc;
    logic        legal;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    assign opcode   = inst_i[6:0];
    assign f3       = inst_i[14:12];
    assign f7       = inst_i[31:25];
    assign imm_i    = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_u    = {inst_i[31:12], 12'b0};
    assign shamt    = {27'b0, inst_i[24:20]};
    assign is_op    = (opcode == OPCODE_OP);
    assign is_imm   = (opcode == OPCODE_OP_IMM);
    assign is_lui   = (opcode == OPCODE_LUI);
    assign is_auipc = (opcode == OPCODE_AUIPC);

    always_comb begin
        op    = ALU_ADD;
        a     = '0;
        b     = '0;
        legal = 1'b0;
        unique case (1'b1)
            is_op: begin
                a     = rs1_i;
                b     = rs2_i;
                legal = 1'b1;
                case ({f7, f3})
                    {7'b0000000, 3'b000}: op = ALU_ADD;
                    {7'b0100000, 3'b000}: op = ALU_SUB;
                    {7'b0000000, 3'b001}: op = ALU_SHIFTL;
                    {7'b0000000, 3'b010}: op = ALU_LESS_THAN_SIGNED;
                    {7'b0000000, 3'b011}: op = ALU_LESS_THAN;
                    {7'b0000000, 3'b100}: op = ALU_XOR;
                    {7'b0000000, 3'b101}: op = ALU_SHIFTR;
                    {7'b0100000, 3'b101}: op = ALU_SHIFTR_ARITH;
                    {7'b0000000, 3'b110}: op = ALU_OR;
                    {7'b0000000, 3'b111}: op = ALU_AND;
                    default:              legal = 1'b0;
                endcase
            end
            is_imm: begin
                a     = rs1_i;
                b     = imm_i;
                legal = 1'b1;
                case (f3)
                    3'b000: op = ALU_ADD;
                    3'b001: begin
                        op    = ALU_SHIFTL;
                        b     = shamt;
                        legal = (f7 == 7'b0000000);
                    end
                    3'b010: op = ALU_LESS_THAN_SIGNED;
                    3'b011: op = ALU_LESS_THAN;
                    3'b100: op = ALU_XOR;
                    3'b101: begin
                        b = shamt;
                        if (f7 == 7'b0000000)
                            op = ALU_SHIFTR;
                        else if (f7 == 7'b0100000)
                            op = ALU_SHIFTR_ARITH;
                        else
                            legal = 1'b0;
                    end
                    3'b110: op = ALU_OR;
                    default: op = ALU_AND;
                endcase
            end
            is_lui: begin
                b     = imm_u;
                legal = 1'b1;
            end
            is_auipc: begin
                a     = pc_i;
                b     = imm_u;
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal bundles still flow, but must look like a harmless ADD 0,0.
    assign op_o      = legal ? op : ALU_ADD;
    assign a_o       = legal ? a : '0;
    assign b_o       = legal ? b : '0;
    assign rd_o      = inst_i[11:7];
    assign rd_we_o   = legal && (inst_i[11:7] != 5'd0);
    assign illegal_o = !legal;

endmodule

// File: rtl/riscv_base_alu_issue.sv
// ALU issue stage: registered decode with valid/ready on both sides.
// Define RISCV_BASE_ALU_ISSUE_SKID_EN for a 2-entry main+skid buffer.
module riscv_base_alu_issue
    import riscv_base_alu_issue_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_inst_i,
    input  logic [31:0] in_pc_i,
    input  logic [31:0] in_rs1_val_i,
    input  logic [31:0] in_rs2_val_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [4:0]  rd_o,
    output logic        rd_we_o,
    output logic        illegal_o
);

    alu_req_t dec;
    alu_req_t main_q;
    logic     in_fire;
    logic     out_fire;

    riscv_base_alu_decode u_decode (
        .inst_i    (in_inst_i),
        .pc_i      (in_pc_i),
        .rs1_i     (in_rs1_val_i),
        .rs2_i     (in_rs2_val_i),
        .op_o      (dec.op),
        .a_o       (dec.a),
        .b_o       (dec.b),
        .rd_o      (dec.rd),
        .rd_we_o   (dec.rd_we),
        .illegal_o (dec.illegal)
    );

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;

`ifdef RISCV_BASE_ALU_ISSUE_SKID_EN

    buf_state_e state_q;
    buf_state_e state_d;
    alu_req_t   main_d;
    alu_req_t   skid_q;
    alu_req_t   skid_d;
    logic       in_ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (in_fire) state_d = ST_ONE;
            ST_ONE: begin
                if (in_fire && !out_fire)
                    state_d = ST_FULL;
                else if (!in_fire && out_fire)
                    state_d = ST_EMPTY;
            end
            ST_FULL: if (out_fire) state_d = ST_ONE;
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid_o = (state_q != ST_EMPTY);
        in_ready_o  = in_ready_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // Main always feeds the outputs; skid only catches the overflow.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        unique case (state_q)
            ST_EMPTY: if (in_fire) main_d = dec;
            ST_ONE: begin
                if (in_fire && out_fire)
                    main_d = dec;
                else if (in_fire)
                    skid_d = dec;
            end
            ST_FULL: if (out_fire) main_d = skid_q;
            default: main_d = main_q;
        endcase
    end

`else

    logic valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            main_q  <= '0;
        end else if (in_fire) begin
            valid_q <= 1'b1;
            main_q  <= dec;
        end else if (out_fire) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign in_ready_o  = !valid_q || out_ready_i;

`endif

    assign alu_op_o  = main_q.op;
    assign alu_a_o   = main_q.a;
    assign alu_b_o   = main_q.b;
    assign rd_o      = main_q.rd;
    assign rd_we_o   = main_q.rd_we;
    assign illegal_o = main_q.illegal;

endmodule

// File: tb/tb_riscv_base_alu_issue.sv
// Scoreboard bench for riscv_base_alu_issue (default or skid build).
// Random + directed RV32I ALU bundles against a behavioural model.
module tb_riscv_base_alu_issue;
    import riscv_base_defines::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_inst_i = '0;
    logic [31:0] in_pc_i = '0;
    logic [31:0] in_rs1_val_i = '0;
    logic [31:0] in_rs2_val_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [4:0]  rd_o;
    logic        rd_we_o;
    logic        illegal_o;

`ifdef RISCV_BASE_ALU_ISSUE_SKID_EN
    localparam int BP_ACCEPTS = 2;
`else
    localparam int BP_ACCEPTS = 1;
`endif

    always #5 clk = ~clk;

    riscv_base_alu_issue dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_inst_i    (in_inst_i),
        .in_pc_i      (in_pc_i),
        .in_rs1_val_i (in_rs1_val_i),
        .in_rs2_val_i (in_rs2_val_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .alu_op_o     (alu_op_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .rd_o         (rd_o),
        .rd_we_o      (rd_we_o),
        .illegal_o    (illegal_o)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   ready_mode = 0;

    function automatic logic [3:0] f3_to_op(input logic [2:0] f3);
        case (f3)
            3'd0: return ALU_ADD;
            3'd1: return ALU_SHIFTL;
            3'd2: return ALU_LESS_THAN_SIGNED;
            3'd3: return ALU_LESS_THAN;
            3'd4: return ALU_XOR;
            3'd5: return ALU_SHIFTR;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] inst, pc, r1, r2);
        exp_t        e;
        logic [6:0]  opc = inst[6:0];
        logic [2:0]  f3 = inst[14:12];
        logic [6:0]  f7 = inst[31:25];
        logic [31:0] immi = {{20{inst[31]}}, inst[31:20]};
        logic [31:0] immu = {inst[31:12], 12'h000};
        logic [31:0] sh = {27'd0, inst[24:20]};
        e.op = ALU_ADD; e.a = 0; e.b = 0; e.ill = 1; e.rd = inst[11:7];
        if (opc == OPCODE_LUI) begin
            e.ill = 0; e.b = immu;
        end else if (opc == OPCODE_AUIPC) begin
            e.ill = 0; e.a = pc; e.b = immu;
        end else if (opc == OPCODE_OP) begin
            e.a = r1; e.b = r2;
            if (f7 == 7'h00) begin
                e.ill = 0; e.op = f3_to_op(f3);
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                e.ill = 0; e.op = ALU_SUB;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                e.ill = 0; e.op = ALU_SHIFTR_ARITH;
            end
        end else if (opc == OPCODE_OP_IMM) begin
            e.a = r1; e.b = immi; e.op = f3_to_op(f3); e.ill = 0;
            if (f3 == 3'd1) begin
                e.b = sh; e.ill = (f7 != 7'h00);
            end else if (f3 == 3'd5) begin
                e.b = sh;
                if (f7 == 7'h20) e.op = ALU_SHIFTR_ARITH;
                else if (f7 != 7'h00) e.ill = 1;
            end
        end
        if (e.ill) begin
            e.op = ALU_ADD; e.a = 0; e.b = 0;
        end
        e.we = !e.ill && (e.rd != 0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready_i = 1'b1;
            1: out_ready_i = 1'b0;
            default: out_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compare presented outputs, then log accepted inputs.
    exp_t        me;
    logic        h_v = 1'b0;
    logic [3:0]  h_op;
    logic [31:0] h_a, h_b;
    logic [4:0]  h_rd;
    logic        h_we, h_ill;

    always @(negedge clk) begin
        if (rst_i) begin
            sbq.delete();
            h_v = 1'b0;
        end else begin
            if (h_v) begin
                check("stable_op", 32'(alu_op_o), 32'(h_op));
                check("stable_a", alu_a_o, h_a);
                check("stable_b", alu_b_o, h_b);
                check("stable_rd", 32'(rd_o), 32'(h_rd));
                check("stable_we", 32'(rd_we_o), 32'(h_we));
                check("stable_ill", 32'(illegal_o), 32'(h_ill));
            end
            if (out_valid_o && out_ready_i) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got op=%h a=%h expected none",
                             alu_op_o, alu_a_o);
                end else begin
                    me = sbq.pop_front();
                    check("sb_op", 32'(alu_op_o), 32'(me.op));
                    check("sb_a", alu_a_o, me.a);
                    check("sb_b", alu_b_o, me.b);
                    check("sb_rd", 32'(rd_o), 32'(me.rd));
                    check("sb_we", 32'(rd_we_o), 32'(me.we));
                    check("sb_ill", 32'(illegal_o), 32'(me.ill));
                end
            end
            h_v = out_valid_o && !out_ready_i;
            h_op = alu_op_o; h_a = alu_a_o; h_b = alu_b_o;
            h_rd = rd_o; h_we = rd_we_o; h_ill = illegal_o;
            if (in_valid_i && in_ready_o)
                sbq.push_back(model(in_inst_i, in_pc_i, in_rs1_val_i, in_rs2_val_i));
        end
    end

    task automatic send(input logic [31:0] inst, pc, r1, r2, output int cyc);
        bit got = 0;
        cyc = 0;
        in_valid_i = 1'b1;
        in_inst_i = inst; in_pc_i = pc;
        in_rs1_val_i = r1; in_rs2_val_i = r2;
        while (!got && cyc < 64) begin
            @(negedge clk);
            got = in_ready_o;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid_i = 1'b0;
        check("send_accepted", 32'(got), 32'd1);
    endtask

    task automatic directed(input logic [31:0] inst, pc, r1, r2,
                            input logic [3:0] eop, input logic [31:0] ea, eb,
                            input logic [4:0] erd, input logic ewe, eill);
        int c;
        send(inst, pc, r1, r2, c);
        @(negedge clk);
        check("dir_valid", 32'(out_valid_o), 32'd1);
        check("dir_op", 32'(alu_op_o), 32'(eop));
        check("dir_a", alu_a_o, ea);
        check("dir_b", alu_b_o, eb);
        check("dir_rd", 32'(rd_o), 32'(erd));
        check("dir_we", 32'(rd_we_o), 32'(ewe));
        check("dir_ill", 32'(illegal_o), 32'(eill));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        check(name, 32'(sbq.size()), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid_o), 32'd0);
        check({tag, "_op"}, 32'(alu_op_o), 32'd0);
        check({tag, "_a"}, alu_a_o, 32'd0);
        check({tag, "_b"}, alu_b_o, 32'd0);
        check({tag, "_rd"}, 32'(rd_o), 32'd0);
        check({tag, "_we"}, 32'(rd_we_o), 32'd0);
        check({tag, "_ill"}, 32'(illegal_o), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w = $urandom;
        logic [6:0]  f7;
        case ($urandom_range(0, 2))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        case ($urandom_range(0, 5))
            0: w = {f7, w[24:7], OPCODE_OP};
            1: w = {w[31:7], OPCODE_OP_IMM};
            2: w = {w[31:7], OPCODE_LUI};
            3: w = {w[31:7], OPCODE_AUIPC};
            4: w = {f7, w[24:15], w[12], 1'b0, 1'b1, w[11:7], OPCODE_OP_IMM};
            default: w = w;
        endcase
        return w;
    endfunction

    logic [31:0] bp_inst [3];
    int          acc;
    int          cyc;
    int          tot;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1;

        directed(32'hFFF08293, 32'h0, 32'h10, 32'h1234, ALU_ADD,
                 32'h10, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0);
        directed(32'h402081B3, 32'h4, 32'd7, 32'd9, ALU_SUB,
                 32'd7, 32'd9, 5'd3, 1'b1, 1'b0);
        directed(32'h40435393, 32'h8, 32'h80000000, 32'h0, ALU_SHIFTR_ARITH,
                 32'h80000000, 32'd4, 5'd7, 1'b1, 1'b0);
        directed(32'h123450B7, 32'h0, 32'hDEAD, 32'hBEEF, ALU_ADD,
                 32'h0, 32'h12345000, 5'd1, 1'b1, 1'b0);
        directed(32'h00001117, 32'h100, 32'h5, 32'h6, ALU_ADD,
                 32'h100, 32'h1000, 5'd2, 1'b1, 1'b0);
        directed(32'h0000007F, 32'h0, 32'h11, 32'h22, ALU_ADD,
                 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        directed(32'h00100013, 32'h0, 32'h55, 32'h0, ALU_ADD,
                 32'h55, 32'h1, 5'd0, 1'b0, 1'b0);
        directed(32'h02009093, 32'h0, 32'h33, 32'h0, ALU_ADD,
                 32'h0, 32'h0, 5'd1, 1'b0, 1'b1);
        drain("drain_directed");

        // Full throughput: accept and consume in the same cycle.
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            send(rand_inst(), $urandom, $urandom, $urandom, cyc);
            tot += cyc;
        end
        check("throughput_cycles", 32'(tot), 32'd8);
        drain("drain_throughput");

        ready_mode = 2;
        for (int i = 0; i < 400; i++)
            send(rand_inst(), $urandom, $urandom, $urandom, cyc);
        ready_mode = 0;
        drain("drain_random");

        ready_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) bp_inst[i] = rand_inst();
        acc = 0;
        in_valid_i = 1'b1;
        in_inst_i = bp_inst[0];
        in_rs1_val_i = $urandom; in_rs2_val_i = $urandom; in_pc_i = $urandom;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (in_ready_o) acc++;
            @(posedge clk);
            #1;
            if (acc < 3) in_inst_i = bp_inst[acc];
            else in_valid_i = 1'b0;
        end
        @(negedge clk);
        check("bp_accepts", 32'(acc), 32'(BP_ACCEPTS));
        check("bp_in_ready_low", 32'(in_ready_o), 32'd0);
        check("bp_out_valid", 32'(out_valid_o), 32'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        ready_mode = 0;
        for (int i = acc; i < 3; i++)
            send(bp_inst[i], $urandom, $urandom, $urandom, cyc);
        drain("drain_backpressure");

        ready_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        in_valid_i = 1'b1;
        in_inst_i = 32'h00500093;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_valid", 32'(out_valid_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        in_valid_i = 1'b0;
        ready_mode = 0;
        @(negedge clk);
        check_zero_outputs("flush");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flush_no_output", 32'(out_valid_o), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
